// File: rtl/kuuga_refill_arbiter.sv
// kuuga_refill_arbiter: round-robin share of one AXI4 read port between I-cache and D-cache line refills.
// One aligned INCR burst is outstanding at a time; beats stream back combinationally to the owner.
module kuuga_refill_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [1:0]                    req_i,
    input  logic [ADDR_WIDTH-1:0]         addr0_i,
    input  logic [ADDR_WIDTH-1:0]         addr1_i,
    output logic [1:0]                    ack_o,
    output logic [1:0]                    rvalid_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic [$clog2(LINE_WORDS)-1:0] rindex_o,
    output logic [1:0]                    done_o,
    output logic                          err_o,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    output logic [ADDR_WIDTH-1:0]         m_araddr,
    output logic [7:0]                    m_arlen,
    output logic [2:0]                    m_arsize,
    output logic [1:0]                    m_arburst,
    output logic [0:0]                    m_arid,
    input  logic                          m_rvalid,
    output logic                          m_rready,
    input  logic [DATA_WIDTH-1:0]         m_rdata,
    input  logic [1:0]                    m_rresp,
    input  logic                          m_rlast,
    input  logic [0:0]                    m_rid
);
    localparam int IW  = $clog2(LINE_WORDS);
    localparam int OFF = $clog2(LINE_WORDS * DATA_WIDTH / 8);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t          state, state_nx;
    logic            owner, last_grant, err, pick, beat, last, beat_err;
    logic [1:0]      own_oh;
    logic [IW-1:0]   cnt;
    logic [ADDR_WIDTH-1:0] sel_addr;

    assign m_arsize  = 3'($clog2(DATA_WIDTH / 8));
    assign m_arburst = 2'b01;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // On a tie the requester not granted last wins; a lone request always wins.
    always_comb begin
        pick     = ~req_i[0] | (req_i[1] & ~last_grant);
        sel_addr = pick ? addr1_i : addr0_i;
        state_nx = state == IDLE ? (|req_i ? ADDR : IDLE) :
                   state == ADDR ? (m_arready ? DATA : ADDR) :
                   (beat && last ? IDLE : DATA);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            err        <= 1'b0;
            m_araddr   <= '0;
            m_arlen    <= '0;
            m_arid     <= '0;
        end else begin
            if (state == IDLE && |req_i) begin
                owner      <= pick;
                last_grant <= pick;
                m_araddr   <= {sel_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
                m_arlen    <= 8'(LINE_WORDS - 1);
                m_arid     <= pick;
            end
            if (state == ADDR && m_arready) begin
                cnt <= '0;
                err <= 1'b0;
            end
            if (beat) begin
                cnt <= cnt + 1'b1;
                err <= err | beat_err;
            end
        end
    end

    // The beat counter alone ends the burst; RLAST is only cross-checked.
    always_comb begin
        own_oh    = owner ? 2'b10 : 2'b01;
        last      = cnt == IW'(LINE_WORDS - 1);
        beat      = state == DATA && m_rvalid;
        beat_err  = |m_rresp || m_rid != owner || m_rlast != last;
        m_arvalid = state == ADDR;
        m_rready  = state == DATA;
        ack_o     = state == ADDR && m_arready ? own_oh : 2'b00;
        rvalid_o  = beat ? own_oh : 2'b00;
        done_o    = beat && last ? own_oh : 2'b00;
        err_o     = beat && last && (err || beat_err);
        rdata_o   = m_rdata;
        rindex_o  = cnt;
    end
endmodule

// File: tb/tb_kuuga_refill_arbiter.sv
// tb_kuuga_refill_arbiter: table-driven refill bursts plus reset-mid-burst sequence.
module tb_kuuga_refill_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_i;
    logic [31:0] addr0_i, addr1_i;
    logic [1:0]  ack_o, rvalid_o, done_o;
    logic [31:0] rdata_o;
    logic [1:0]  rindex_o;
    logic        err_o;
    logic        m_arvalid, m_arready;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic [0:0]  m_arid;
    logic        m_rvalid, m_rready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast;
    logic [0:0]  m_rid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    kuuga_refill_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .addr0_i(addr0_i), .addr1_i(addr1_i),
        .ack_o(ack_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .rindex_o(rindex_o),
        .done_o(done_o), .err_o(err_o),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arid(m_arid),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast), .m_rid(m_rid)
    );

    typedef struct {
        logic [1:0]  req;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        own;
        logic [31:0] araddr;
        int          bad_beat;
        int          last_beat;
        int          ar_wait;
        logic        err;
    } vec_t;

    vec_t tv[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic reset_outputs_check(input string tag);
        chk({tag, "_arvalid"}, 64'(m_arvalid), 0);
        chk({tag, "_rready"}, 64'(m_rready), 0);
        chk({tag, "_ack"}, 64'(ack_o), 0);
        chk({tag, "_rvalid"}, 64'(rvalid_o), 0);
        chk({tag, "_done"}, 64'(done_o), 0);
        chk({tag, "_err"}, 64'(err_o), 0);
        chk({tag, "_rindex"}, 64'(rindex_o), 0);
        chk({tag, "_araddr"}, 64'(m_araddr), 0);
        chk({tag, "_arlen"}, 64'(m_arlen), 0);
        chk({tag, "_arid"}, 64'(m_arid), 0);
    endtask

    // Called just after a falling edge; returns just after the falling edge that follows the final beat.
    task automatic run(input vec_t v);
        logic [1:0]  oh;
        logic [31:0] d;
        oh = v.own ? 2'b10 : 2'b01;
        req_i = v.req;
        addr0_i = v.a0;
        addr1_i = v.a1;
        m_arready = 1'b0;
        #1 chk("arvalid_pre", 64'(m_arvalid), 0);
        @(negedge clk);
        chk("arvalid", 64'(m_arvalid), 1);
        chk("araddr", 64'(m_araddr), 64'(v.araddr));
        chk("arlen", 64'(m_arlen), 3);
        chk("arsize", 64'(m_arsize), 2);
        chk("arburst", 64'(m_arburst), 1);
        chk("arid", 64'(m_arid), 64'(v.own));
        chk("ack_early", 64'(ack_o), 0);
        for (int w = 0; w < v.ar_wait; w++) begin
            @(negedge clk);
            chk("hold_arvalid", 64'(m_arvalid), 1);
            chk("hold_araddr", 64'(m_araddr), 64'(v.araddr));
            chk("hold_arlen", 64'(m_arlen), 3);
            chk("hold_arid", 64'(m_arid), 64'(v.own));
            chk("hold_ack", 64'(ack_o), 0);
        end
        m_arready = 1'b1;
        #1 chk("ack", 64'(ack_o), 64'(oh));
        @(negedge clk);
        m_arready = 1'b0;
        req_i = req_i & ~oh;
        m_rvalid = 1'b0;
        #1;
        chk("gap_rvalid", 64'(rvalid_o), 0);
        chk("rready", 64'(m_rready), 1);
        chk("ack_after", 64'(ack_o), 0);
        chk("arvalid_data", 64'(m_arvalid), 0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            d = v.araddr ^ (32'(i) * 32'h0101_0101) ^ 32'hD00D_0000;
            m_rvalid = 1'b1;
            m_rdata = d;
            m_rresp = (i == v.bad_beat) ? 2'b10 : 2'b00;
            m_rlast = (i == v.last_beat);
            m_rid = v.own;
            #1;
            chk("rvalid", 64'(rvalid_o), 64'(oh));
            chk("rdata", 64'(rdata_o), 64'(d));
            chk("rindex", 64'(rindex_o), 64'(i));
            chk("done", 64'(done_o), i == 3 ? 64'(oh) : 0);
            chk("err", 64'(err_o), i == 3 ? 64'(v.err) : 0);
            @(negedge clk);
        end
        m_rvalid = 1'b0;
        m_rlast = 1'b0;
        m_rresp = 2'b00;
        #1;
        chk("idle_arvalid", 64'(m_arvalid), 0);
        chk("idle_done", 64'(done_o), 0);
        chk("idle_rready", 64'(m_rready), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        tv[0] = '{2'b11, 32'h2000_0044, 32'h3000_0088, 1'b0, 32'h2000_0040, -1, 3, 0, 1'b0};
        tv[1] = '{2'b11, 32'h2000_0058, 32'h3000_0088, 1'b1, 32'h3000_0080, -1, 3, 0, 1'b0};
        tv[2] = '{2'b11, 32'h4444_444C, 32'h5555_5554, 1'b0, 32'h4444_4440, -1, 3, 0, 1'b0};
        tv[3] = '{2'b10, 32'h0, 32'hABCD_EF0F, 1'b1, 32'hABCD_EF00, -1, 3, 5, 1'b0};
        tv[4] = '{2'b01, 32'h0000_1234, 32'h0, 1'b0, 32'h0000_1230, -1, 3, 0, 1'b0};
        tv[5] = '{2'b01, 32'h0000_0104, 32'h0, 1'b0, 32'h0000_0100, 2, 3, 1, 1'b1};
        tv[6] = '{2'b01, 32'h0000_0118, 32'h0, 1'b0, 32'h0000_0110, -1, 3, 0, 1'b0};
        tv[7] = '{2'b10, 32'h0, 32'h0000_0FFF, 1'b1, 32'h0000_0FF0, -1, 1, 2, 1'b1};
        rst_n = 1'b0;
        req_i = 2'b00;
        addr0_i = '0;
        addr1_i = '0;
        m_arready = 1'b0;
        m_rvalid = 1'b0;
        m_rdata = '0;
        m_rresp = 2'b00;
        m_rlast = 1'b0;
        m_rid = '0;
        @(negedge clk);
        @(negedge clk);
        reset_outputs_check("rst");
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) run(tv[k]);
        req_i = 2'b00;
        // Reset in the middle of a data phase, with the slave still presenting a beat.
        req_i = 2'b01;
        addr0_i = 32'h6000_0010;
        @(negedge clk);
        chk("mid_arvalid", 64'(m_arvalid), 1);
        m_arready = 1'b1;
        @(negedge clk);
        m_arready = 1'b0;
        req_i = 2'b00;
        m_rid = 1'b0;
        m_rvalid = 1'b1;
        m_rdata = 32'h1111_0000;
        @(negedge clk);
        m_rdata = 32'h1111_0001;
        #1 chk("mid_rindex1", 64'(rindex_o), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1 reset_outputs_check("midrst");
        @(negedge clk);
        m_rvalid = 1'b0;
        rst_n = 1'b1;
        rv = '{2'b10, 32'h0, 32'h7777_7777, 1'b1, 32'h7777_7770, -1, 3, 0, 1'b0};
        run(rv);
        req_i = 2'b00;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
